// File: rtl/mem_access_unit_pkg.sv
// Shared types for the memory-access / write-back stage: FSM states,
// write-back select encodings and a helper for word-offset width.
package mem_access_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    localparam logic [2:0] WB_ALU  = 3'd0;
    localparam logic [2:0] WB_MDR  = 3'd1;
    localparam logic [2:0] WB_PC   = 3'd2;
    localparam logic [2:0] WB_IMM  = 3'd3;
    localparam logic [2:0] WB_COMP = 3'd4;

    // Number of byte-offset bits inside one memory word.
    function automatic int unsigned off_bits(input int unsigned data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-state counter for one memory access: cleared when a request is issued,
// counts un-acknowledged WAIT cycles and flags the final allowed one.
module mem_wait_timer #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic CLK,
    input  logic resetN,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired_c
);

    localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

    logic [CNT_W-1:0] r_count;

    // Saturates at MAX_WAIT rather than wrapping.
    always_ff @(posedge CLK or negedge resetN) begin
        if (!resetN) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != CNT_W'(MAX_WAIT))) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // High in the WAIT cycle whose increment brings the count to MAX_WAIT.
    assign o_expired_c = i_enable && (r_count == CNT_W'(MAX_WAIT - 1));

endmodule

// File: rtl/mem_access_unit.sv
// Memory-access and write-back stage of the multicycle core: request/ready
// handshake with wait-state timeout, IR/MDR capture and registered write-back mux.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic              CLK,
    input  logic              resetN,
    input  logic              startRead,
    input  logic              startWrite,
    input  logic              irLoad,
    input  logic              addrSel,
    input  logic [DATA_W-1:0] pc,
    input  logic [DATA_W-1:0] aluOut,
    input  logic [DATA_W-1:0] storeData,
    input  logic [DATA_W-1:0] immGen,
    input  logic [DATA_W-1:0] compOut,
    input  logic [2:0]        wbSel,
    output logic [ADDR_W-1:0] memAddr,
    output logic              memRe,
    output logic              memWe,
    output logic [DATA_W-1:0] memWData,
    input  logic [DATA_W-1:0] memRData,
    input  logic              memReady,
    output logic              busy,
    output logic              done,
    output logic              fault,
    output logic [DATA_W-1:0] instruction,
    output logic [DATA_W-1:0] mdr,
    output logic [DATA_W-1:0] wbData
);

    localparam int unsigned OFF_W = off_bits(DATA_W);

    state_t            r_state;
    state_t            w_state_nxt;

    logic [ADDR_W-1:0] w_byte_addr;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_is_read;
    logic              r_ir_load;
    logic              r_misalign;

    logic              r_re;
    logic              r_we;
    logic              r_busy;
    logic              r_done;
    logic              r_fault;
    logic [DATA_W-1:0] r_ir;
    logic [DATA_W-1:0] r_mdr;
    logic [DATA_W-1:0] r_wb;
    logic [DATA_W-1:0] w_wb_nxt;

    logic              w_start;
    logic              w_issue;
    logic              w_complete;
    logic              w_timeout;
    logic              w_misfault;
    logic              w_timer_clr;
    logic              w_timer_en;
    logic              w_expired;

    assign w_byte_addr = addrSel ? ADDR_W'(aluOut) : ADDR_W'(pc);

    assign w_timer_clr = (r_state == REQ);
    assign w_timer_en  = (r_state == WAIT) && !memReady;

    mem_wait_timer #(
        .MAX_WAIT    (MAX_WAIT)
    ) u_wait_timer (
        .CLK         (CLK),
        .resetN      (resetN),
        .i_clear     (w_timer_clr),
        .i_enable    (w_timer_en),
        .o_expired_c (w_expired)
    );

    // State register.
    always_ff @(posedge CLK or negedge resetN) begin
        if (!resetN) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and per-cycle events; memReady wins over the timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_issue     = 1'b0;
        w_complete  = 1'b0;
        w_timeout   = 1'b0;
        w_misfault  = 1'b0;
        case (r_state)
            IDLE: begin
                if (startRead || startWrite) begin
                    w_start     = 1'b1;
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                if (r_misalign) begin
                    w_misfault  = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_issue     = 1'b1;
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (memReady) begin
                    w_complete  = 1'b1;
                    w_state_nxt = IDLE;
                end else if (w_expired) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Access latch, strobes, status pulses and IR/MDR capture.
    always_ff @(posedge CLK or negedge resetN) begin
        if (!resetN) begin
            r_mem_addr <= '0;
            r_wdata    <= '0;
            r_is_read  <= 1'b0;
            r_ir_load  <= 1'b0;
            r_misalign <= 1'b0;
            r_re       <= 1'b0;
            r_we       <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_fault    <= 1'b0;
            r_ir       <= '0;
            r_mdr      <= '0;
        end else begin
            r_busy  <= (w_state_nxt != IDLE);
            r_done  <= w_complete;
            r_fault <= w_misfault | w_timeout;

            if (w_start) begin
                r_mem_addr <= ADDR_W'(w_byte_addr >> OFF_W);
                r_wdata    <= storeData;
                r_is_read  <= startRead;
                r_ir_load  <= irLoad;
                r_misalign <= |w_byte_addr[OFF_W-1:0];
            end

            if (w_issue) begin
                r_re <= r_is_read;
                r_we <= !r_is_read;
            end else if (w_complete || w_timeout) begin
                r_re <= 1'b0;
                r_we <= 1'b0;
            end

            if (w_complete && r_is_read) begin
                if (r_ir_load) begin
                    r_ir <= memRData;
                end else begin
                    r_mdr <= memRData;
                end
            end
        end
    end

    // Write-back source select; unused encodings fall back to the ALU result.
    always_comb begin
        w_wb_nxt = aluOut;
        case (wbSel)
            WB_ALU:  w_wb_nxt = aluOut;
            WB_MDR:  w_wb_nxt = r_mdr;
            WB_PC:   w_wb_nxt = pc;
            WB_IMM:  w_wb_nxt = immGen;
            WB_COMP: w_wb_nxt = compOut;
            default: w_wb_nxt = aluOut;
        endcase
    end

    always_ff @(posedge CLK or negedge resetN) begin
        if (!resetN) begin
            r_wb <= '0;
        end else begin
            r_wb <= w_wb_nxt;
        end
    end

    assign memAddr     = r_mem_addr;
    assign memRe       = r_re;
    assign memWe       = r_we;
    assign memWData    = r_wdata;
    assign busy        = r_busy;
    assign done        = r_done;
    assign fault       = r_fault;
    assign instruction = r_ir;
    assign mdr         = r_mdr;
    assign wbData      = r_wb;

endmodule
